// File: rtl/hndshk_src_arbiter.sv
// Source-domain controller sharing one four-phase CDC handshake port between
// NUM_REQ requesters: round-robin grant, payload capture, req/ack sequencing.
module hndshk_src_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                        src_clk,
  input  logic                        src_reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        hs_req,
  output logic [DATA_W-1:0]           hs_data,
  input  logic                        hs_ack,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [31:0]                 xfer_count,
  output logic                        timeout_err,
  input  logic                        timeout_clr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TMO_EN = (TIMEOUT > 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_LOW} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [31:0]         xfer_q, xfer_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                terr_q, terr_d;
  logic                tmo_set;

  logic [DATA_W-1:0]   req_words [NUM_REQ];
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand;

  // Round-robin search starting one past the last winner, wrapping.
  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_words[i] = req_data[i*DATA_W +: DATA_W];
    end
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    xfer_d    = xfer_q;
    timer_d   = timer_q;
    tmo_set   = 1'b0;
    req_ready = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          grant_d = win_idx;
          ptr_d   = win_idx;
          data_d  = req_words[win_idx];
          timer_d = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (hs_ack) begin
          xfer_d  = xfer_q + 32'd1;
          timer_d = '0;
          state_d = ST_WAIT_LOW;
        end else if (TMO_EN && timer_q == TMR_LAST) begin
          tmo_set = 1'b1;
          timer_d = '0;
          state_d = ST_WAIT_LOW;
        end else if (TMO_EN) begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WAIT_LOW: begin
        if (!hs_ack) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (TMO_EN && timer_q == TMR_LAST) begin
          tmo_set = 1'b1;
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (TMO_EN) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A timeout in the same cycle as a clear request keeps the flag set.
    terr_d = tmo_set | (terr_q & ~timeout_clr);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of evaluation order.
  always_ff @(posedge src_clk or negedge src_reset_n) begin
    if (!src_reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      xfer_q  <= '0;
      timer_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      xfer_q  <= xfer_d;
      timer_q <= timer_d;
      terr_q  <= terr_d;
    end
  end

  assign hs_req      = (state_q == ST_REQ);
  assign busy        = (state_q != ST_IDLE);
  assign hs_data     = data_q;
  assign grant_id    = grant_q;
  assign xfer_count  = xfer_q;
  assign timeout_err = terr_q;

endmodule
